// File: rtl/cpu_reg_pkg.sv
// Register-file index/pair encodings and write-back scheduler state shared across the CPU.
package cpu_reg_pkg;

  typedef enum logic [2:0] {
    REG_B = 3'd0,
    REG_C = 3'd1,
    REG_D = 3'd2,
    REG_E = 3'd3,
    REG_H = 3'd4,
    REG_L = 3'd5,
    REG_F = 3'd6,
    REG_A = 3'd7
  } reg_idx_e;

  typedef enum logic [1:0] {
    PAIR_BC = 2'd0,
    PAIR_DE = 2'd1,
    PAIR_HL = 2'd2,
    PAIR_AF = 2'd3
  } reg_pair_e;

  typedef enum logic {
    IDLE    = 1'b0,
    PAIR_LO = 1'b1
  } wb_state_e;

  localparam logic [2:0] REG_F_IDX = 3'd6;

  function automatic reg_idx_e pair_hi(input reg_pair_e p);
    case (p)
      PAIR_BC: pair_hi = REG_B;
      PAIR_DE: pair_hi = REG_D;
      PAIR_HL: pair_hi = REG_H;
      default: pair_hi = REG_A;
    endcase
  endfunction

  // AF is the odd one out: the flag register sits below A in index order.
  function automatic reg_idx_e pair_lo(input reg_pair_e p);
    case (p)
      PAIR_BC: pair_lo = REG_C;
      PAIR_DE: pair_lo = REG_E;
      PAIR_HL: pair_lo = REG_L;
      default: pair_lo = REG_F;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter: fixed priority (req 0 wins) or round-robin via a last-grant pointer.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_fixed,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);

  // last_q=1 means requester 1 won last, so requester 0 is favoured out of reset.
  logic last_q;

  always_comb begin
    o_gnt = '0;
    if (i_req[0] && i_req[1]) begin
      if (i_fixed || last_q) o_gnt = 2'b01;
      else                   o_gnt = 2'b10;
    end else if (i_req[0]) begin
      o_gnt = 2'b01;
    end else if (i_req[1]) begin
      o_gnt = 2'b10;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_q <= 1'b1;
    end else if (i_advance && (o_gnt != 2'b00)) begin
      last_q <= o_gnt[1];
    end
  end

endmodule

// File: rtl/reg_wb_sched.sv
// Register-file write-back scheduler: ALU/MEM arbitration, pair writes split hi-then-lo.
// Optional macro REG_WB_FLAG_MASK_EN clears data[3:0] on every write to F (index 6).
module reg_wb_sched
  import cpu_reg_pkg::*;
#(
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned DATA_W   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_alu_valid,
  output logic                  o_alu_ready,
  input  logic [2:0]            i_alu_sel,
  input  logic [DATA_W-1:0]     i_alu_data,
  input  logic                  i_mem_valid,
  output logic                  o_mem_ready,
  input  logic                  i_mem_pair,
  input  logic [2:0]            i_mem_sel,
  input  logic [1:0]            i_mem_psel,
  input  logic [2*DATA_W-1:0]   i_mem_data,
  output logic                  o_reg_wr_en,
  output logic [2:0]            o_reg_wr_sel,
  output logic [DATA_W-1:0]     o_reg_wr_data,
  output logic                  o_busy
);

`ifdef REG_WB_FLAG_MASK_EN
  localparam logic FLAG_MASK = 1'b1;
`else
  localparam logic FLAG_MASK = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] wb_mask(input logic [2:0] idx,
                                                input logic [DATA_W-1:0] d);
    wb_mask = d;
    if (FLAG_MASK && (idx == REG_F_IDX)) wb_mask[3:0] = '0;
  endfunction

  wb_state_e          state_q;
  logic [2:0]         lo_sel_q;
  logic [DATA_W-1:0]  lo_data_q;
  logic               wr_en_q;
  logic [2:0]         wr_sel_q;
  logic [DATA_W-1:0]  wr_data_q;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       alu_acc;
  logic       mem_acc;
  logic [2:0] hi_idx;
  logic [2:0] lo_idx;

  // Requests are masked during PAIR_LO so the two beats of a pair stay adjacent.
  assign req = {i_mem_valid, i_alu_valid} & {2{state_q == IDLE}};

  rr_arb2 u_arb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (req),
    .i_fixed   (ARB_MODE == 1),
    .i_advance (alu_acc || mem_acc),
    .o_gnt     (gnt)
  );

  assign alu_acc     = gnt[0];
  assign mem_acc     = gnt[1];
  assign o_alu_ready = gnt[0];
  assign o_mem_ready = gnt[1];

  assign hi_idx = pair_hi(reg_pair_e'(i_mem_psel));
  assign lo_idx = pair_lo(reg_pair_e'(i_mem_psel));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      lo_sel_q  <= '0;
      lo_data_q <= '0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (alu_acc) begin
            wr_en_q   <= 1'b1;
            wr_sel_q  <= i_alu_sel;
            wr_data_q <= wb_mask(i_alu_sel, i_alu_data);
          end else if (mem_acc) begin
            wr_en_q <= 1'b1;
            if (i_mem_pair) begin
              wr_sel_q  <= hi_idx;
              wr_data_q <= wb_mask(hi_idx, i_mem_data[2*DATA_W-1:DATA_W]);
              lo_sel_q  <= lo_idx;
              lo_data_q <= i_mem_data[DATA_W-1:0];
              state_q   <= PAIR_LO;
            end else begin
              wr_sel_q  <= i_mem_sel;
              wr_data_q <= wb_mask(i_mem_sel, i_mem_data[DATA_W-1:0]);
            end
          end
        end
        PAIR_LO: begin
          wr_en_q   <= 1'b1;
          wr_sel_q  <= lo_sel_q;
          wr_data_q <= wb_mask(lo_sel_q, lo_data_q);
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_reg_wr_en   = wr_en_q;
  assign o_reg_wr_sel  = wr_sel_q;
  assign o_reg_wr_data = wr_data_q;
  assign o_busy        = wr_en_q || (state_q == PAIR_LO);

endmodule

// File: tb/tb_reg_wb_sched.sv
// Scoreboard bench for reg_wb_sched: round-robin instance fully modelled, fixed-priority instance spot-checked.
module tb_reg_wb_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        alu_v, alu_rdy, mem_v, mem_rdy, mem_pair;
  logic [2:0]  alu_sel, mem_sel;
  logic [7:0]  alu_data;
  logic [1:0]  mem_psel;
  logic [15:0] mem_data;
  logic        wr_en, busy;
  logic [2:0]  wr_sel;
  logic [7:0]  wr_data;

  logic        b_alu_v, b_alu_rdy, b_mem_v, b_mem_rdy, b_mem_pair;
  logic [2:0]  b_alu_sel, b_mem_sel;
  logic [7:0]  b_alu_data;
  logic [1:0]  b_mem_psel;
  logic [15:0] b_mem_data;
  logic        b_wr_en, b_busy;
  logic [2:0]  b_wr_sel;
  logic [7:0]  b_wr_data;

  reg_wb_sched #(.ARB_MODE(0), .DATA_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alu_valid(alu_v), .o_alu_ready(alu_rdy), .i_alu_sel(alu_sel), .i_alu_data(alu_data),
    .i_mem_valid(mem_v), .o_mem_ready(mem_rdy), .i_mem_pair(mem_pair), .i_mem_sel(mem_sel),
    .i_mem_psel(mem_psel), .i_mem_data(mem_data),
    .o_reg_wr_en(wr_en), .o_reg_wr_sel(wr_sel), .o_reg_wr_data(wr_data), .o_busy(busy)
  );

  reg_wb_sched #(.ARB_MODE(1), .DATA_W(8)) dut_fix (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alu_valid(b_alu_v), .o_alu_ready(b_alu_rdy), .i_alu_sel(b_alu_sel), .i_alu_data(b_alu_data),
    .i_mem_valid(b_mem_v), .o_mem_ready(b_mem_rdy), .i_mem_pair(b_mem_pair), .i_mem_sel(b_mem_sel),
    .i_mem_psel(b_mem_psel), .i_mem_data(b_mem_data),
    .o_reg_wr_en(b_wr_en), .o_reg_wr_sel(b_wr_sel), .o_reg_wr_data(b_wr_data), .o_busy(b_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [7:0] m_mask(input logic [2:0] idx, input logic [7:0] d);
`ifdef REG_WB_FLAG_MASK_EN
    if (idx == 3'd6) return {d[7:4], 4'h0};
`endif
    return d;
  endfunction

  function automatic logic [2:0] m_hi(input logic [1:0] p);
    case (p)
      2'd0: return 3'd0;
      2'd1: return 3'd2;
      2'd2: return 3'd4;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] m_lo(input logic [1:0] p);
    case (p)
      2'd0: return 3'd1;
      2'd1: return 3'd3;
      2'd2: return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  typedef struct {
    int         cyc;
    logic [2:0] sel;
    logic [7:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    cyc      = 0;
  int    blocked  = -1;
  logic  last_mem = 1'b1;

  always @(negedge clk) begin : mon
    beat_t b;
    logic  ea, em, beat;
    if (!rst_n) begin
      exp_q.delete();
      blocked  = -1;
      last_mem = 1'b1;
      chk("rst_wr_en", {15'd0, wr_en}, 16'd0);
      chk("rst_sel", {13'd0, wr_sel}, 16'd0);
      chk("rst_data", {8'd0, wr_data}, 16'd0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_fix_wr_en", {15'd0, b_wr_en}, 16'd0);
    end else begin
      beat = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        b = exp_q.pop_front();
        beat = 1'b1;
        chk("wr_en", {15'd0, wr_en}, 16'd1);
        chk("wr_sel", {13'd0, wr_sel}, {13'd0, b.sel});
        chk("wr_data", {8'd0, wr_data}, {8'd0, b.data});
      end else begin
        chk("wr_idle", {15'd0, wr_en}, 16'd0);
      end
      chk("busy", {15'd0, busy}, {15'd0, beat || (cyc == blocked)});
      ea = (cyc != blocked) && alu_v && (!mem_v || last_mem);
      em = (cyc != blocked) && mem_v && !ea;
      chk("alu_ready", {15'd0, alu_rdy}, {15'd0, ea});
      chk("mem_ready", {15'd0, mem_rdy}, {15'd0, em});
      if (ea) begin
        exp_q.push_back('{cyc + 1, alu_sel, m_mask(alu_sel, alu_data)});
        last_mem = 1'b0;
      end else if (em) begin
        last_mem = 1'b1;
        if (mem_pair) begin
          exp_q.push_back('{cyc + 1, m_hi(mem_psel), m_mask(m_hi(mem_psel), mem_data[15:8])});
          exp_q.push_back('{cyc + 2, m_lo(mem_psel), m_mask(m_lo(mem_psel), mem_data[7:0])});
          blocked = cyc + 1;
        end else begin
          exp_q.push_back('{cyc + 1, mem_sel, m_mask(mem_sel, mem_data[7:0])});
        end
      end
    end
    cyc++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic alu_req(input logic [2:0] sel, input logic [7:0] data);
    logic got = 1'b0;
    alu_v = 1'b1; alu_sel = sel; alu_data = data;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (alu_rdy) begin got = 1'b1; break; end
    end
    if (!got) chk("alu_timeout", 16'd0, 16'd1);
    @(posedge clk); #1;
    alu_v = 1'b0;
  endtask

  task automatic mem_req(input logic pair, input logic [2:0] sel, input logic [1:0] psel,
                         input logic [15:0] data);
    logic got = 1'b0;
    mem_v = 1'b1; mem_pair = pair; mem_sel = sel; mem_psel = psel; mem_data = data;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_rdy) begin got = 1'b1; break; end
    end
    if (!got) chk("mem_timeout", 16'd0, 16'd1);
    @(posedge clk); #1;
    mem_v = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    alu_v = 1'b0; alu_sel = '0; alu_data = '0;
    mem_v = 1'b0; mem_pair = 1'b0; mem_sel = '0; mem_psel = '0; mem_data = '0;
    b_alu_v = 1'b0; b_alu_sel = '0; b_alu_data = '0;
    b_mem_v = 1'b0; b_mem_pair = 1'b0; b_mem_sel = '0; b_mem_psel = '0; b_mem_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    alu_req(3'd7, 8'h3C);
    idle(2);
    mem_req(1'b1, 3'd6, 2'd2, 16'hBEEF);
    idle(3);
    mem_req(1'b1, 3'd1, 2'd3, 16'h12FF);
    idle(3);
    mem_req(1'b0, 3'd6, 2'd3, 16'h55AB);
    alu_req(3'd6, 8'h5F);
    idle(2);

    fork
      for (int i = 0; i < 4; i++) alu_req(3'(i), 8'(8'h10 + i));
      for (int j = 0; j < 4; j++) mem_req(1'b0, 3'(j + 4), 2'd0, 16'(16'h0A20 + j));
    join
    idle(2);

    mem_req(1'b1, 3'd7, 2'd0, 16'h1234);
    alu_req(3'd2, 8'h99);
    idle(3);

    fork
      for (int i = 0; i < 10; i++) begin
        idle($urandom_range(0, 2));
        alu_req(3'($urandom_range(0, 7)), 8'($urandom));
      end
      for (int j = 0; j < 10; j++) begin
        idle($urandom_range(0, 2));
        mem_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)), 16'($urandom));
      end
    join
    idle(4);

    mem_req(1'b1, 3'd0, 2'd1, 16'hCAFE);
    #2;
    chk("pre_rst_busy", {15'd0, busy}, 16'd1);
    chk("pre_rst_hi_sel", {13'd0, wr_sel}, 16'd2);
    rst_n = 1'b0;
    #1;
    chk("async_wr_en", {15'd0, wr_en}, 16'd0);
    chk("async_busy", {15'd0, busy}, 16'd0);
    chk("async_sel", {13'd0, wr_sel}, 16'd0);
    chk("async_data", {8'd0, wr_data}, 16'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle(4);

    b_alu_v = 1'b1; b_alu_sel = 3'd1; b_alu_data = 8'h11;
    b_mem_v = 1'b1; b_mem_pair = 1'b0; b_mem_sel = 3'd2; b_mem_data = 16'h0022;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fix_alu_ready", {15'd0, b_alu_rdy}, 16'd1);
      chk("fix_mem_ready", {15'd0, b_mem_rdy}, 16'd0);
      if (i > 0) begin
        chk("fix_wr_en", {15'd0, b_wr_en}, 16'd1);
        chk("fix_wr_sel", {13'd0, b_wr_sel}, 16'd1);
        chk("fix_wr_data", {8'd0, b_wr_data}, 16'h0011);
      end
    end
    @(posedge clk); #1;
    b_alu_v = 1'b0;
    @(negedge clk);
    chk("fix_mem_lone", {15'd0, b_mem_rdy}, 16'd1);
    @(posedge clk); #1;
    b_mem_v = 1'b0;
    @(negedge clk);
    chk("fix_mem_wr_sel", {13'd0, b_wr_sel}, 16'd2);
    chk("fix_mem_wr_data", {8'd0, b_wr_data}, 16'h0022);

    idle(2);
    chk("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_wb_sched.md
Name: reg_wb_sched

Overview:
Write-back scheduler for the CPU's 8-register file, which has a single 8-bit write port. It arbitrates between two requesters: the ALU (8-bit writes) and the load/pop unit (8-bit or 16-bit register-pair writes). It sequences each pair write as two 8-bit beats, high byte first, and the two beats of a pair are never interleaved with another write. It sits between the execute/memory stages and the register file write port.

Parameters:
ARB_MODE, 0, 0 = round-robin between ALU and MEM; 1 = fixed priority, ALU wins.
DATA_W, 8, register width; pair data is 2*DATA_W.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_alu_valid  in  1  ALU write request
o_alu_ready  out  1  ALU request accepted this cycle
i_alu_sel  in  3  ALU target register index
i_alu_data  in  DATA_W  ALU write data
i_mem_valid  in  1  MEM write request
o_mem_ready  out  1  MEM request accepted this cycle
i_mem_pair  in  1  1 = 16-bit pair write, 0 = 8-bit write
i_mem_sel  in  3  MEM target register (pair=0)
i_mem_psel  in  2  MEM target pair: 0=BC 1=DE 2=HL 3=AF (pair=1)
i_mem_data  in  2*DATA_W  MEM data; [7:0] used when pair=0, {hi,lo} when pair=1
o_reg_wr_en  out  1  register file write enable
o_reg_wr_sel  out  3  register file write index
o_reg_wr_data  out  DATA_W  register file write data
o_busy  out  1  a write is in flight (output beat valid or low byte pending)

Behaviour:
- Clock/reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Register index encoding: B=0 C=1 D=2 E=3 H=4 L=5 F=6 A=7.
- Pair mapping: BC->(0,1), DE->(2,3), HL->(4,5), AF->(7,6), given as (high, low).
- Reset: state=IDLE, o_reg_wr_en=0, o_reg_wr_sel=0, o_reg_wr_data=0, o_busy=0, RR pointer favours ALU.
- Reset mid-pair drops the pending low byte. No write occurs after reset release until a new request is accepted.
- Handshake: ready is combinational from valid and state. A transfer occurs when valid&&ready. Requesters hold valid, sel and data stable until ready.
- Only one of o_alu_ready and o_mem_ready is high in any cycle.
- Write-port outputs are registered. A request accepted in cycle N drives o_reg_wr_en=1 in cycle N+1, otherwise wr_en=0.
- FSM IDLE:
  - Grant per ARB_MODE when any valid.
  - Single-byte accept: drive write at N+1; stay IDLE.
  - Pair accept: at N+1 drive hi index and data[15:8]; latch lo index and data[7:0]; go PAIR_LO.
- FSM PAIR_LO:
  - Both readies are 0.
  - Next cycle drives the latched low byte; return to IDLE.
  - A pair therefore occupies the write port for 2 consecutive cycles. A new request can be accepted in the cycle after PAIR_LO, so the low beat is followed directly by the next write.
- Throughput: single writes back-to-back at 1 per cycle.
- Round-robin:
  - When both requesters are valid, grant the one not granted last. The pointer updates only on an accepted transfer.
  - A lone valid is always granted.
- ARB_MODE=1: ALU always wins a tie. MEM can starve; this is acceptable.
- o_busy = o_reg_wr_en || (state==PAIR_LO).
- i_mem_sel and i_mem_psel are ignored when not selected by i_mem_pair.
- Index 6 written as a single byte is legal (F).

Optional Feature:
REG_WB_FLAG_MASK_EN:
- Defined: any write whose target index is 6 (F) has data bits [3:0] forced to 0 on o_reg_wr_data. This applies to single writes and to the AF-pair low beat.
- Undefined: data passes unmodified.

Decomposition:
- Package cpu_reg_pkg:
  - reg_idx_e enum (B..A) and reg_pair_e enum (BC, DE, HL, AF).
  - Functions pair_hi(reg_pair_e) and pair_lo(reg_pair_e) returning reg_idx_e.
  - localparam REG_F_IDX=6.
  - wb_state_e {IDLE, PAIR_LO}.
- Sub-module rr_arb2: 2-requester arbiter with a last-grant pointer, a mode input for fixed/round-robin, and an advance-on-accept input. It is reusable elsewhere in the CPU.

Test Plan:
- ALU alone, sel=7 data=0x3C accepted cycle N -> wr_en=1, sel=7, data=0x3C at N+1; wr_en=0 at N+2.
- MEM pair psel=2 (HL) data=0xBEEF -> N+1: sel=4 data=0xEF... correction: N+1: sel=4 data=0xBE; N+2: sel=5 data=0xEF. o_mem_ready=0 and o_alu_ready=0 in N+1. o_busy=1 for N+1..N+2.
- Both valid every cycle, ARB_MODE=0, single writes -> grants alternate ALU, MEM, ALU, MEM. With ARB_MODE=1 -> ALU every cycle, o_mem_ready never 1.
- AF pair data=0x12FF with REG_WB_FLAG_MASK_EN -> beats (7,0x12) then (6,0xF0). Without the macro -> (6,0xFF).
- Reset asserted in PAIR_LO -> outputs 0 immediately (asynchronously). After release no low-byte write is issued and state is IDLE.
- MEM pair immediately followed by a pending ALU request -> ALU is held off during PAIR_LO, accepted the next cycle, and its write appears one cycle after the low beat.
